// File: rtl/axi_ar_arbiter.sv
// ---------------------------------------------------------------------------
// axi_ar_arbiter
//
// Read-address-channel arbiter sitting between the AXI masters (M0 instruction
// fetch, M1 data, M2 DMA) and the address decoder. One master is granted per
// transaction using a round-robin priority pointer. The grant is registered
// and held until the AR handshake completes, so payload never switches in the
// middle of a transaction. The outgoing ID carries the master index in its
// upper nibble so the read-data path can route responses back.
//
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   ARID_M/ARADDR_M/...     packed per-master AR payload, master i at [i*W +: W]
//   ARVALID_M / ARREADY_M   per-master handshake
//   ID_S/ADDR_S/LEN_S/...   granted payload towards the decoder
//   VALID_S / READY_S       decoder-side handshake
//   GRANT                   one-hot current grant (debug, R-channel return mux)
// ---------------------------------------------------------------------------
module axi_ar_arbiter #(
    parameter int unsigned NUM_M = 3,
    parameter int unsigned IDW   = 4,
    parameter int unsigned SIDW  = 8,
    parameter int unsigned AW    = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [NUM_M*IDW-1:0] ARID_M,
    input  logic [NUM_M*AW-1:0]  ARADDR_M,
    input  logic [NUM_M*4-1:0]   ARLEN_M,
    input  logic [NUM_M*3-1:0]   ARSIZE_M,
    input  logic [NUM_M*2-1:0]   ARBURST_M,
    input  logic [NUM_M-1:0]     ARVALID_M,
    output logic [NUM_M-1:0]     ARREADY_M,
    output logic [SIDW-1:0]      ID_S,
    output logic [AW-1:0]        ADDR_S,
    output logic [3:0]           LEN_S,
    output logic [2:0]           SIZE_S,
    output logic [1:0]           BURST_S,
    output logic                 VALID_S,
    input  logic                 READY_S,
    output logic [NUM_M-1:0]     GRANT
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       gidx_q;
    logic [NUM_M-1:0] grant_q;

    logic [3:0]       req4;
    logic [1:0]       cand;
    logic [1:0]       win_idx;
    logic             win_found;
    logic             busy;
    logic [1:0]       next_ptr;

    assign busy  = (state_q == ST_BUSY);
    assign req4  = 4'(ARVALID_M);
    assign GRANT = grant_q;

    // Round-robin scan: first requester at ptr, ptr+1, ... modulo NUM_M.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            cand = 2'((32'(ptr_q) + k) % NUM_M);
            if (!win_found && req4[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign next_ptr = (gidx_q == 2'(NUM_M - 1)) ? '0 : gidx_q + 2'd1;

    // Payload mux from the granted master; everything reads 0 while idle.
    always_comb begin
        ID_S      = '0;
        ADDR_S    = '0;
        LEN_S     = '0;
        SIZE_S    = '0;
        BURST_S   = '0;
        VALID_S   = 1'b0;
        ARREADY_M = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (busy && gidx_q == 2'(i)) begin
                ID_S         = SIDW'({4'(i), ARID_M[i*IDW +: IDW]});
                ADDR_S       = ARADDR_M[i*AW +: AW];
                LEN_S        = ARLEN_M[i*4 +: 4];
                SIZE_S       = ARSIZE_M[i*3 +: 3];
                BURST_S      = ARBURST_M[i*2 +: 2];
                VALID_S      = ARVALID_M[i];
                ARREADY_M[i] = READY_S;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_q <= ST_BUSY;
                        gidx_q  <= win_idx;
                        grant_q <= NUM_M'(1) << win_idx;
                    end
                end
                ST_BUSY: begin
                    if (!VALID_S) begin
                        // Granted master withdrew its request: drop it, keep priority.
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end else if (READY_S) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= next_ptr;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_ar_arbiter
//
// Directed bench for axi_ar_arbiter with three masters. Inputs change 1 ns
// after the rising edge and outputs are checked another 1 ns later.
// ---------------------------------------------------------------------------
module tb_axi_ar_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [11:0] arid_m;
    logic [95:0] araddr_m;
    logic [11:0] arlen_m;
    logic [8:0]  arsize_m;
    logic [5:0]  arburst_m;
    logic [2:0]  arvalid_m;
    logic [2:0]  arready_m;
    logic [7:0]  id_s;
    logic [31:0] addr_s;
    logic [3:0]  len_s;
    logic [2:0]  size_s;
    logic [1:0]  burst_s;
    logic        valid_s;
    logic        ready_s;
    logic [2:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    axi_ar_arbiter #(.NUM_M(3), .IDW(4), .SIDW(8), .AW(32)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ARID_M    (arid_m),
        .ARADDR_M  (araddr_m),
        .ARLEN_M   (arlen_m),
        .ARSIZE_M  (arsize_m),
        .ARBURST_M (arburst_m),
        .ARVALID_M (arvalid_m),
        .ARREADY_M (arready_m),
        .ID_S      (id_s),
        .ADDR_S    (addr_s),
        .LEN_S     (len_s),
        .SIZE_S    (size_s),
        .BURST_S   (burst_s),
        .VALID_S   (valid_s),
        .READY_S   (ready_s),
        .GRANT     (grant)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_m(input int i, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
        arid_m[i*4 +: 4]    = id;
        araddr_m[i*32 +: 32] = addr;
        arlen_m[i*4 +: 4]   = len;
        arsize_m[i*3 +: 3]  = 3'd2;
        arburst_m[i*2 +: 2] = 2'b01;
    endtask

    initial begin
        logic [2:0] exp_g [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;

        ARESET = 1'b1; arvalid_m = '0; ready_s = 1'b0;
        set_m(0, 4'h5, 32'h1000_0000, 4'd1);
        set_m(1, 4'h3, 32'h0001_0040, 4'd3);
        set_m(2, 4'hA, 32'h2000_0080, 4'd7);
        cyc(); cyc();
        #1;
        check("rst_valid", valid_s, 0);
        check("rst_grant", grant, 0);
        check("rst_arready", arready_m, 0);
        check("rst_id", id_s, 0);
        check("rst_addr", addr_s, 0);

        // Single M1 request after reset
        ARESET = 1'b0; arvalid_m = 3'b010; ready_s = 1'b1; #1;
        check("idle_valid", valid_s, 0);
        check("idle_arready", arready_m, 0);
        cyc();
        check("m1_valid", valid_s, 1);
        check("m1_addr", addr_s, 32'h0001_0040);
        check("m1_id", id_s, 8'h13);
        check("m1_len", len_s, 4'd3);
        check("m1_size", size_s, 3'd2);
        check("m1_burst", burst_s, 2'b01);
        check("m1_grant", grant, 3'b010);
        check("m1_arready", arready_m, 3'b010);
        cyc();
        arvalid_m = '0; #1;
        check("m1_done_valid", valid_s, 0);
        check("m1_done_grant", grant, 0);
        check("m1_done_arready", arready_m, 0);

        // Wrap-around: ptr=2, only M0 requesting
        arvalid_m = 3'b001;
        cyc();
        check("wrap_grant", grant, 3'b001);
        check("wrap_id", id_s, 8'h05);
        cyc();
        arvalid_m = 3'b011;  // ptr should now be 1 -> M1 beats M0
        cyc();
        check("wrap_ptr1", grant, 3'b010);
        cyc();

        // Three-way contention from reset
        ARESET = 1'b1; arvalid_m = 3'b111;
        cyc(); cyc();
        check("rr_rst_grant", grant, 0);
        check("rr_rst_valid", valid_s, 0);
        ARESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("rr_grant", grant, exp_g[k]);
            check("rr_valid", valid_s, 1);
            check("rr_idnib", id_s[7:4], (k == 3) ? 0 : k);
            check("rr_arready", arready_m, exp_g[k]);
            cyc();
            check("rr_gap_valid", valid_s, 0);
            check("rr_gap_grant", grant, 0);
        end

        // Slave stall on M0 with M2 requesting during it
        arvalid_m = 3'b001; ready_s = 1'b0;
        cyc();
        arvalid_m = 3'b101;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_grant", grant, 3'b001);
            check("stall_addr", addr_s, 32'h1000_0000);
            check("stall_id", id_s, 8'h05);
            check("stall_arready", arready_m, 0);
            check("stall_valid", valid_s, 1);
            cyc();
        end
        ready_s = 1'b1; #1;
        check("stall_hs_arready", arready_m, 3'b001);
        cyc();
        arvalid_m = 3'b100; #1;
        check("stall_gap_valid", valid_s, 0);
        cyc();
        check("stall_m2_grant", grant, 3'b100);
        check("stall_m2_id", id_s, 8'h2A);
        check("stall_m2_addr", addr_s, 32'h2000_0080);
        cyc();

        // Reset mid-transaction with ptr=1
        arvalid_m = 3'b001; ready_s = 1'b1;
        cyc();
        check("pre_rst_m0", grant, 3'b001);
        cyc();
        arvalid_m = 3'b100; ready_s = 1'b0;
        cyc();
        check("mid_grant_m2", grant, 3'b100);
        arvalid_m = 3'b101; ARESET = 1'b1;
        cyc();
        check("mid_rst_valid", valid_s, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_arready", arready_m, 0);
        ARESET = 1'b0;
        cyc();
        check("regrant_ptr0", grant, 3'b001);

        // ARVALID drop by granted M1 (ptr=1 after this handshake)
        ready_s = 1'b1;
        cyc();
        arvalid_m = 3'b010; ready_s = 1'b0;
        cyc();
        check("drop_grant", grant, 3'b010);
        arvalid_m = 3'b000; #1;
        check("drop_valid", valid_s, 0);
        check("drop_arready", arready_m, 0);
        cyc();
        check("drop_idle_grant", grant, 0);
        check("drop_idle_valid", valid_s, 0);
        arvalid_m = 3'b011;
        cyc();
        check("drop_ptr_kept", grant, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ar_arbiter.md
Name: axi_ar_arbiter

Overview:
- Read-address-channel arbiter between the AXI masters (M0 instruction fetch, M1 data, M2 DMA) and the address decoder.
- Selects one master per transaction with round-robin priority and holds that grant until the AR handshake completes.
- Presents a single VALID/ADDR/ID/attribute stream to the decoder and returns the decoder's combined READY to the granted master only.
- Tags the outgoing ID with the master index so the read-data return path can route responses back.

Parameters:
- NUM_M, 3, number of masters; legal range 2..4.
- IDW, 4, per-master ARID width.
- SIDW, 8, slave-side ID width; equals IDW+4, with the upper 4 bits holding the master index.
- AW, 32, address width.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- ARID_M  in  NUM_M*IDW  packed per-master ARID; master i occupies slice [i*IDW +: IDW].
- ARADDR_M  in  NUM_M*AW  packed per-master ARADDR.
- ARLEN_M  in  NUM_M*4  packed ARLEN.
- ARSIZE_M  in  NUM_M*3  packed ARSIZE.
- ARBURST_M  in  NUM_M*2  packed ARBURST.
- ARVALID_M  in  NUM_M  per-master ARVALID.
- ARREADY_M  out  NUM_M  per-master ARREADY.
- ID_S  out  SIDW  {4'(grant index), ARID of granted master}.
- ADDR_S  out  AW  granted address, sent to the decoder.
- LEN_S  out  4  granted ARLEN.
- SIZE_S  out  3  granted ARSIZE.
- BURST_S  out  2  granted ARBURST.
- VALID_S  out  1  granted ARVALID, sent to the decoder.
- READY_S  in  1  combined slave READY from the decoder.
- GRANT  out  NUM_M  one-hot current grant, for debug and for the R-channel return mux.

Behaviour:
- Single clock ACLK. ARESET is synchronous and active-high.
- State machine with two states:
  - IDLE: no grant. VALID_S=0, ARREADY_M=0, GRANT=0. Other payload outputs are 0.
  - BUSY: one master granted. Payload outputs, VALID_S and ID_S are combinationally muxed from the granted master. ARREADY_M[g]=READY_S; all other ARREADY_M bits are 0.
- Reset values:
  - State=IDLE.
  - Priority pointer ptr=0.
  - Grant register=0.
  - All outputs 0.
- Reset asserted in any state forces these values on the next edge. Any in-flight un-handshaked request is dropped, and masters must re-present it.
- IDLE -> BUSY:
  - Triggers on a clock edge where any ARVALID_M bit is 1.
  - Grant goes to the first set bit scanning ptr, ptr+1, ..., wrapping modulo NUM_M.
  - The grant is registered, so VALID_S rises exactly 1 cycle after the ARVALID_M sample that won.
- BUSY -> IDLE:
  - Triggers on the edge where VALID_S && READY_S, i.e. the handshake.
  - On that edge, ptr <= (g+1) mod NUM_M.
  - The arbiter spends at least one IDLE cycle between transactions, giving a peak rate of 1 transfer per 2 cycles.
- Grant hold:
  - While in BUSY, no re-arbitration occurs regardless of other masters' requests.
  - Payload is never switched mid-transaction.
- Protocol violation: if the granted master deasserts ARVALID before the handshake, the next edge returns to IDLE with ptr unchanged.
- Simultaneous requests: all NUM_M masters valid in the same cycle are served strictly in round-robin order starting at ptr. Each waiting master's ARREADY_M stays 0 until its grant.
- Wrap-around: ptr after serving master NUM_M-1 is 0.
- ID tagging: ID_S[SIDW-1:IDW] = grant index zero-extended to 4 bits; ID_S[IDW-1:0] = ARID of the granted master.
- READY_S is ignored in IDLE.
- ARREADY_M is never asserted to a master that is not granted.

Test Plan:
- Reset then single request: assert ARESET for 2 cycles; then M1 asserts ARVALID with ARADDR=0x0001_0040, ARID=3, ARLEN=3, and READY_S=1. Required: VALID_S=1 one cycle later, ADDR_S=0x0001_0040, ID_S=0x13, LEN_S=3, GRANT=3'b010; ARREADY_M[1]=1 for exactly that cycle; returns to IDLE next cycle; ptr=2.
- Three-way contention: all three masters hold ARVALID from reset, and READY_S=1 always. Required grant sequence M0, M1, M2, M0 with VALID_S pulses every 2nd cycle; ID_S upper nibble 0,1,2,0.
- Slave stall: M0 is granted with READY_S=0 for 5 cycles, and M2 requests during the stall. Required: ADDR_S/ID_S stable for all 5 cycles; ARREADY_M all 0; no switch to M2. After READY_S=1 for one cycle, M2 is granted next.
- Wrap-around: ptr=2 with only M0 requesting. Required: M0 granted; ptr becomes 1 after the handshake.
- Reset mid-transaction: in BUSY with READY_S=0, assert ARESET. Required: next edge gives VALID_S=0, GRANT=0, ARREADY_M=0; after release, the still-valid master is re-granted starting from ptr=0.
- ARVALID drop: granted M1 deasserts ARVALID before READY_S. Required: returns to IDLE; ptr unchanged; no ARREADY_M pulse; VALID_S=0.
